// File: rtl/rr_hold_arbiter.sv
// Registered round-robin arbiter with grant hold (lock) semantics.
// Optional hold limit with forced release: define ARB_HOLD_LIMIT_EN.
module rr_hold_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int MAX_HOLD   = 8
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [REQUESTERS-1:0]         req_i,
  output logic [REQUESTERS-1:0]         grant_o,
  output logic                          grant_valid_o,
  output logic [$clog2(REQUESTERS)-1:0] grant_idx_o,
  output logic                          hold_expire_o
);

  localparam int              IDXW     = $clog2(REQUESTERS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(REQUESTERS - 1);
  localparam logic [IDXW:0]   N_WIDE   = (IDXW + 1)'(REQUESTERS);

  if (REQUESTERS < 2 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("rr_hold_arbiter: REQUESTERS must be >= 2 and MAX_HOLD >= 1");
  end

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e                  state_q, state_d;
  logic [IDXW-1:0]         ptr_q, ptr_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic [REQUESTERS-1:0]   grant_q, grant_d;
  logic                    valid_q, valid_d;
  logic                    expire_q, expire_d;

  logic [IDXW-1:0]         next_idx;
  logic [IDXW-1:0]         scan_start;
  logic [IDXW-1:0]         win_idx;
  logic                    win_found;
  logic [IDXW:0]           cand;
  logic                    force_rel;
  logic                    load_grant;

  // In IDLE the scan starts at ptr; on a release it starts just past the owner,
  // which is exactly where ptr is heading, so the owner is considered last.
  assign next_idx   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
  assign scan_start = (state_q == IDLE) ? ptr_q : next_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      cand = {1'b0, scan_start} + (IDXW + 1)'(i);
      if (cand >= N_WIDE) begin
        cand = cand - N_WIDE;
      end
      if (!win_found && req_i[cand[IDXW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDXW-1:0];
      end
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  localparam int            CW        = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] hold_cnt_q, hold_cnt_d;

  assign force_rel = (state_q == BUSY) && req_i[idx_q] && (hold_cnt_q == HOLD_LAST);

  // Counts BUSY cycles of the current owner; every fresh grant restarts it.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (load_grant) begin
      hold_cnt_d = '0;
    end else if (state_q == BUSY && hold_cnt_q != HOLD_LAST) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_cnt_q <= '0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  logic unused_load_grant;

  assign force_rel         = 1'b0;
  assign unused_load_grant = load_grant;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    valid_d    = valid_q;
    expire_d   = 1'b0;
    load_grant = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          load_grant = 1'b1;
        end
      end
      BUSY: begin
        if (!req_i[idx_q] || force_rel) begin
          ptr_d    = next_idx;
          expire_d = force_rel;
          if (win_found) begin
            load_grant = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (load_grant) begin
      state_d          = BUSY;
      grant_d          = '0;
      grant_d[win_idx] = 1'b1;
      idx_d            = win_idx;
      valid_d          = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      expire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      expire_q <= expire_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = valid_q;
  assign grant_idx_o   = idx_q;
  assign hold_expire_o = expire_q;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed self-checking bench for rr_hold_arbiter (REQUESTERS=4, MAX_HOLD=8).
module tb_rr_hold_arbiter;

  logic       clk;
  logic       resetn;
  logic [3:0] req_i;
  logic [3:0] grant_o;
  logic       grant_valid_o;
  logic [1:0] grant_idx_o;
  logic       hold_expire_o;

  int checks;
  int errors;

  rr_hold_arbiter #(
    .REQUESTERS(4),
    .MAX_HOLD  (8)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_i        (req_i),
    .grant_o      (grant_o),
    .grant_valid_o(grant_valid_o),
    .grant_idx_o  (grant_idx_o),
    .hold_expire_o(hold_expire_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge so outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    req_i  = 4'b0000;
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req_i  = 4'hF;
    step();
    step();
    checks++;
    if (grant_o !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_grant: got %b expected %b", grant_o, 4'b0000);
    end
    checks++;
    if (grant_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %b expected %b", grant_valid_o, 1'b0);
    end
    checks++;
    if (grant_idx_o !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_idx: got %0d expected 0", grant_idx_o);
    end
    checks++;
    if (hold_expire_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_expire: got %b expected 0", hold_expire_o);
    end
    resetn = 1'b1;
    step();
    checks++;
    if (grant_o !== 4'b0001 || grant_idx_o !== 2'd0 || grant_valid_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_first_grant: got grant=%b idx=%0d valid=%b expected grant=0001 idx=0 valid=1",
               grant_o, grant_idx_o, grant_valid_o);
    end
  endtask

  // Owner drops its request, the previous owner re-raises: grants walk 1,2,3,0.
  task automatic test_rotation();
    int         cur;
    int         nxt;
    logic [3:0] exp_grant;
    cur = 0;
    for (int k = 0; k < 4; k++) begin
      req_i = 4'hF & ~(4'b0001 << cur);
      step();
      nxt       = (cur + 1) % 4;
      exp_grant = 4'b0001 << nxt;
      checks++;
      if (grant_o !== exp_grant || grant_idx_o !== 2'(nxt) || grant_valid_o !== 1'b1) begin
        errors++;
        $display("[TB] FAIL rotation_%0d: got grant=%b idx=%0d valid=%b expected grant=%b idx=%0d valid=1",
                 k, grant_o, grant_idx_o, grant_valid_o, exp_grant, nxt);
      end
      cur = nxt;
    end
  endtask

  task automatic test_wrap();
    req_i = 4'b0110;
    step();
    checks++;
    if (grant_o !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL wrap_setup1: got %b expected 0010", grant_o);
    end
    req_i = 4'b0100;
    step();
    checks++;
    if (grant_o !== 4'b0100) begin
      errors++;
      $display("[TB] FAIL wrap_setup2: got %b expected 0100", grant_o);
    end
    req_i = 4'b0011;
    step();
    checks++;
    if (grant_o !== 4'b0001 || grant_idx_o !== 2'd0) begin
      errors++;
      $display("[TB] FAIL wrap_grant: got grant=%b idx=%0d expected grant=0001 idx=0", grant_o, grant_idx_o);
    end
    req_i = 4'b0000;
    step();
    checks++;
    if (grant_o !== 4'b0000 || grant_valid_o !== 1'b0 || grant_idx_o !== 2'd0) begin
      errors++;
      $display("[TB] FAIL wrap_idle: got grant=%b valid=%b idx=%0d expected grant=0000 valid=0 idx=0",
               grant_o, grant_valid_o, grant_idx_o);
    end
  endtask

  task automatic test_hold();
    int bad;
    do_reset();
    req_i = 4'b0101;
    step();
    checks++;
    if (grant_o !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL hold_first: got %b expected 0001", grant_o);
    end
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if (grant_o !== 4'b0001 || hold_expire_o !== 1'b0) begin
        errors++;
        bad++;
        if (bad < 4) begin
          $display("[TB] FAIL hold_cycle_%0d: got grant=%b expire=%b expected grant=0001 expire=0",
                   c, grant_o, hold_expire_o);
        end
      end
    end
    req_i = 4'b0100;
    step();
    checks++;
    if (grant_o !== 4'b0100 || grant_idx_o !== 2'd2) begin
      errors++;
      $display("[TB] FAIL hold_handoff: got grant=%b idx=%0d expected grant=0100 idx=2", grant_o, grant_idx_o);
    end
  endtask

  // ptr=3 with requesters 0 and 3 pending: 3 wins, 0 follows after release.
  task automatic test_simultaneous();
    do_reset();
    req_i = 4'b0100;
    step();
    req_i = 4'b0000;
    step();
    checks++;
    if (grant_valid_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL simul_idle: got valid=%b expected 0", grant_valid_o);
    end
    req_i = 4'b1001;
    step();
    checks++;
    if (grant_o !== 4'b1000 || grant_idx_o !== 2'd3) begin
      errors++;
      $display("[TB] FAIL simul_first: got grant=%b idx=%0d expected grant=1000 idx=3", grant_o, grant_idx_o);
    end
    req_i = 4'b0001;
    step();
    checks++;
    if (grant_o !== 4'b0001 || grant_idx_o !== 2'd0) begin
      errors++;
      $display("[TB] FAIL simul_second: got grant=%b idx=%0d expected grant=0001 idx=0", grant_o, grant_idx_o);
    end
  endtask

  task automatic test_midop_reset();
    req_i = 4'b0010;
    step();
    checks++;
    if (grant_o !== 4'b0010) begin
      errors++;
      $display("[TB] FAIL midreset_setup: got %b expected 0010", grant_o);
    end
    #2;
    resetn = 1'b0;
    req_i  = 4'hF;
    #1;
    checks++;
    if (grant_o !== 4'b0000 || grant_valid_o !== 1'b0 || grant_idx_o !== 2'd0) begin
      errors++;
      $display("[TB] FAIL midreset_async: got grant=%b valid=%b idx=%0d expected grant=0000 valid=0 idx=0",
               grant_o, grant_valid_o, grant_idx_o);
    end
    step();
    resetn = 1'b1;
    step();
    checks++;
    if (grant_o !== 4'b0001 || grant_idx_o !== 2'd0) begin
      errors++;
      $display("[TB] FAIL midreset_restart: got grant=%b idx=%0d expected grant=0001 idx=0", grant_o, grant_idx_o);
    end
  endtask

  task automatic test_limit();
    logic [3:0] exp_grant;
    logic       exp_exp;
    do_reset();
    req_i = 4'b0011;
    step();
    checks++;
    if (grant_o !== 4'b0001 || hold_expire_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL limit_first: got grant=%b expire=%b expected grant=0001 expire=0", grant_o, hold_expire_o);
    end
    for (int s = 1; s <= 24; s++) begin
      step();
      exp_grant = (((s / 8) % 2) == 0) ? 4'b0001 : 4'b0010;
      exp_exp   = ((s % 8) == 0);
      checks++;
      if (grant_o !== exp_grant || hold_expire_o !== exp_exp) begin
        errors++;
        $display("[TB] FAIL limit_alt_%0d: got grant=%b expire=%b expected grant=%b expire=%b",
                 s, grant_o, hold_expire_o, exp_grant, exp_exp);
      end
    end
    do_reset();
    req_i = 4'b0001;
    step();
    for (int s = 1; s <= 17; s++) begin
      step();
      exp_exp = ((s % 8) == 0);
      checks++;
      if (grant_o !== 4'b0001 || hold_expire_o !== exp_exp) begin
        errors++;
        $display("[TB] FAIL limit_solo_%0d: got grant=%b expire=%b expected grant=0001 expire=%b",
                 s, grant_o, hold_expire_o, exp_exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    resetn = 1'b0;
    req_i  = 4'b0000;
    test_reset();
    test_rotation();
    test_wrap();
`ifdef ARB_HOLD_LIMIT_EN
    test_limit();
`else
    test_hold();
`endif
    test_simultaneous();
    test_midop_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
